// File: rtl/voice_scheduler.sv
// Polyphonic voice allocator and per-sample slot sequencer for the synth datapath.
// Optional feature macro: VOICE_STEAL_EN (overflow note-on steals a slot round-robin).
module voice_scheduler #(
  parameter  int NUM_VOICES = 4,
  parameter  int ROM_LAT    = 2,
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          EV_VALID,
  output logic          EV_READY,
  input  logic          EV_NOTE_ON,
  input  logic [6:0]    EV_NOTE,
  output logic          EV_DROP,
  input  logic          FIFO_FULL,
  output logic          VOICE_STROBE,
  output logic [VW-1:0] VOICE_IDX,
  output logic [6:0]    VOICE_NOTE,
  output logic          VOICE_ACTIVE,
  output logic          FIFO_WRITE,
  output logic [VW:0]   ACTIVE_COUNT
);

  typedef enum logic [2:0] {
    IDLE, ALLOC, STROBE, WAIT, EMIT
  } state_t;

  state_t state, state_n;

  logic [VW-1:0]         idx, idx_n;
  logic [2:0]            cnt, cnt_n;
  logic                  ev_on;
  logic [6:0]            ev_note;
  logic [NUM_VOICES-1:0] act, act_n;
  logic [6:0]            note   [NUM_VOICES];
  logic [6:0]            note_n [NUM_VOICES];
  logic [VW:0]           count_n;
  logic [VW-1:0]         last_idx;
  logic [6:0]            last_note;
  logic                  last_act;
  logic                  drop;
  logic                  hit;
  logic                  free;
  logic [VW-1:0]         free_idx;
  logic                  in_range;
`ifdef VOICE_STEAL_EN
  logic [VW-1:0]         ptr, ptr_n;
`endif

  // Lowest-index free slot and duplicate detection over the current snapshot
  always_comb begin
    in_range = (ev_note >= 7'd12) && (ev_note <= 7'd119);
    hit      = 1'b0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (act[i] && note[i] == ev_note) hit = 1'b1;
      if (!act[i]) begin
        free     = 1'b1;
        free_idx = VW'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    act_n   = act;
    note_n  = note;
    drop    = 1'b0;
`ifdef VOICE_STEAL_EN
    ptr_n   = ptr;
`endif
    unique case (state)
      IDLE: begin
        if (EV_VALID) begin
          state_n = ALLOC;
        end else if (!FIFO_FULL) begin
          idx_n   = '0;
          state_n = STROBE;
        end
      end
      ALLOC: begin
        state_n = IDLE;
        if (ev_on) begin
          if (in_range && !hit) begin
            if (free) begin
              act_n[free_idx]  = 1'b1;
              note_n[free_idx] = ev_note;
            end else begin
`ifdef VOICE_STEAL_EN
              note_n[ptr] = ev_note;
              ptr_n = (ptr == VW'(NUM_VOICES - 1)) ? '0 : ptr + 1'b1;
`else
              drop = 1'b1;
`endif
            end
          end
        end else begin
          for (int i = 0; i < NUM_VOICES; i++)
            if (note[i] == ev_note) act_n[i] = 1'b0;
        end
      end
      STROBE: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (cnt == 3'(ROM_LAT - 1)) begin
          if (idx == VW'(NUM_VOICES - 1)) begin
            state_n = EMIT;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = STROBE;
          end
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      EMIT:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    count_n = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      count_n = count_n + {{VW{1'b0}}, act_n[i]};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      ev_on        <= 1'b0;
      ev_note      <= '0;
      act          <= '0;
      ACTIVE_COUNT <= '0;
      last_idx     <= '0;
      last_note    <= '0;
      last_act     <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) note[i] <= '0;
`ifdef VOICE_STEAL_EN
      ptr          <= '0;
`endif
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      act          <= act_n;
      note         <= note_n;
      ACTIVE_COUNT <= count_n;
`ifdef VOICE_STEAL_EN
      ptr          <= ptr_n;
`endif
      if (state == IDLE && EV_VALID) begin
        ev_on   <= EV_NOTE_ON;
        ev_note <= EV_NOTE;
      end
      // Voice bus holds the last presented slot between strobes
      if (state == STROBE) begin
        last_idx  <= idx;
        last_note <= note[idx];
        last_act  <= act[idx];
      end
    end
  end

  assign EV_READY     = (state == IDLE);
  assign EV_DROP      = drop;
  assign VOICE_STROBE = (state == STROBE);
  assign VOICE_IDX    = VOICE_STROBE ? idx : last_idx;
  assign VOICE_NOTE   = VOICE_STROBE ? note[idx] : last_note;
  assign VOICE_ACTIVE = VOICE_STROBE ? act[idx] : last_act;
  assign FIFO_WRITE   = (state == EMIT);

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: reference slot model plus a queue of
// expected strobe / fifo-write events with their exact cycle numbers.
module tb_voice_scheduler;

  localparam int NV = 4;
  localparam int VW = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          EV_VALID;
  logic          EV_READY;
  logic          EV_NOTE_ON;
  logic [6:0]    EV_NOTE;
  logic          EV_DROP;
  logic          FIFO_FULL;
  logic          VOICE_STROBE;
  logic [VW-1:0] VOICE_IDX;
  logic [6:0]    VOICE_NOTE;
  logic          VOICE_ACTIVE;
  logic          FIFO_WRITE;
  logic [VW:0]   ACTIVE_COUNT;

  voice_scheduler #(.NUM_VOICES(NV), .ROM_LAT(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .EV_VALID(EV_VALID), .EV_READY(EV_READY),
    .EV_NOTE_ON(EV_NOTE_ON), .EV_NOTE(EV_NOTE),
    .EV_DROP(EV_DROP), .FIFO_FULL(FIFO_FULL),
    .VOICE_STROBE(VOICE_STROBE), .VOICE_IDX(VOICE_IDX),
    .VOICE_NOTE(VOICE_NOTE), .VOICE_ACTIVE(VOICE_ACTIVE),
    .FIFO_WRITE(FIFO_WRITE), .ACTIVE_COUNT(ACTIVE_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            cyc;
    bit            fw;
    logic [VW-1:0] idx;
    logic [6:0]    note;
    logic          act;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   ncmp  = 0;
  int   nfail = 0;

  bit       mact  [NV];
  bit [6:0] mnote [NV];
  int       mptr;

  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe or fifo write must match the queue head
  always @(negedge CLK) begin
    exp_t e;
    if (VOICE_STROBE === 1'b1 || FIFO_WRITE === 1'b1) begin
      ncmp++;
      if (q.size() == 0) begin
        nfail++;
        $error("FAIL unexpected_output cyc=%0d strobe=%b write=%b expected none",
               cyc, VOICE_STROBE, FIFO_WRITE);
      end else begin
        e = q.pop_front();
        if (e.fw) begin
          assert (FIFO_WRITE === 1'b1 && VOICE_STROBE === 1'b0 && cyc === e.cyc)
          else begin
            nfail++;
            $error("FAIL fifo_write observed cyc=%0d w=%b s=%b expected cyc=%0d w=1",
                   cyc, FIFO_WRITE, VOICE_STROBE, e.cyc);
          end
        end else begin
          assert (VOICE_STROBE === 1'b1 && FIFO_WRITE === 1'b0 &&
                  cyc === e.cyc && VOICE_IDX === e.idx &&
                  VOICE_NOTE === e.note && VOICE_ACTIVE === e.act)
          else begin
            nfail++;
            $error("FAIL strobe observed cyc=%0d idx=%0d note=%0d act=%b expected cyc=%0d idx=%0d note=%0d act=%b",
                   cyc, VOICE_IDX, VOICE_NOTE, VOICE_ACTIVE,
                   e.cyc, e.idx, e.note, e.act);
          end
        end
      end
    end
  end

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < NV; i++) c += int'(mact[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      mact[i]  = 0;
      mnote[i] = '0;
    end
    mptr = 0;
  endtask

  task automatic model_ev(input bit on, input logic [6:0] n, output bit drop);
    bit hit;
    int fr;
    drop = 0;
    if (on) begin
      if (n >= 12 && n <= 119) begin
        hit = 0;
        fr  = -1;
        for (int i = 0; i < NV; i++)
          if (mact[i] && mnote[i] == n) hit = 1;
        for (int i = NV - 1; i >= 0; i--)
          if (!mact[i]) fr = i;
        if (!hit) begin
          if (fr >= 0) begin
            mact[fr]  = 1;
            mnote[fr] = n;
          end else begin
`ifdef VOICE_STEAL_EN
            mnote[mptr] = n;
            mptr = (mptr + 1) % NV;
`else
            drop = 1;
`endif
          end
        end
      end
    end else begin
      for (int i = 0; i < NV; i++)
        if (mnote[i] == n) mact[i] = 0;
    end
  endtask

  // Sample started from IDLE at cycle base: strobes at base+1+3i, write at base+13
  task automatic push_sample(input int base, input int nvo, input bit fw);
    exp_t e;
    for (int i = 0; i < nvo; i++) begin
      e.cyc  = base + 1 + 3 * i;
      e.fw   = 0;
      e.idx  = VW'(i);
      e.note = mnote[i];
      e.act  = mact[i];
      q.push_back(e);
    end
    if (fw) begin
      e.cyc  = base + 13;
      e.fw   = 1;
      e.idx  = '0;
      e.note = '0;
      e.act  = 0;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge CLK);
      w++;
    end
    chk("scoreboard_drained", q.size(), 0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic run_samples(input int n, input bit rel);
    int k;
    @(negedge CLK);
    k = cyc;
    for (int s = 0; s < n; s++) push_sample(k + 14 * s, NV, 1);
    if (rel) RESET = 1'b0;
    FIFO_FULL = 1'b0;
    repeat (14 * (n - 1) + 1) @(negedge CLK);
    FIFO_FULL = 1'b1;
    drain();
  endtask

  task automatic send_ev(input bit on, input logic [6:0] n);
    bit d;
    int w;
    @(negedge CLK);
    EV_VALID   = 1'b1;
    EV_NOTE_ON = on;
    EV_NOTE    = n;
    w = 0;
    while (EV_READY !== 1'b1 && w < 50) begin
      @(negedge CLK);
      w++;
    end
    chk("ev_ready_timeout", 32'(w < 50), 1);
    @(negedge CLK);
    EV_VALID = 1'b0;
    model_ev(on, n, d);
    chk("ev_drop", EV_DROP, d);
    @(negedge CLK);
    chk("ev_drop_one_cycle", EV_DROP, 0);
    chk("active_count", ACTIVE_COUNT, mcount());
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    int  w;
    bit  d;
    RESET      = 1'b1;
    EV_VALID   = 1'b0;
    EV_NOTE_ON = 1'b0;
    EV_NOTE    = '0;
    FIFO_FULL  = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);

    chk("rst_ev_ready", EV_READY, 1);
    chk("rst_strobe", VOICE_STROBE, 0);
    chk("rst_fifo_write", FIFO_WRITE, 0);
    chk("rst_ev_drop", EV_DROP, 0);
    chk("rst_count", ACTIVE_COUNT, 0);
    chk("rst_voice_bus", {VOICE_IDX, VOICE_NOTE, VOICE_ACTIVE}, 0);

    // Free-running empty samples straight out of reset
    run_samples(2, 1);

    send_ev(1, 7'd60);
    send_ev(1, 7'd64);
    send_ev(1, 7'd67);
    run_samples(1, 0);
    send_ev(1, 7'd64);
    send_ev(0, 7'd64);
    send_ev(1, 7'd72);
    run_samples(1, 0);

    // Overflow: drop or steal depending on build
    send_ev(1, 7'd76);
    send_ev(1, 7'd80);
    run_samples(1, 0);
    send_ev(1, 7'd81);
    run_samples(1, 0);

    // Event arriving mid-sample waits for IDLE and wins over the next sample
    @(negedge CLK);
    k = cyc;
    push_sample(k, NV, 1);
    FIFO_FULL = 1'b0;
    repeat (2) @(negedge CLK);
    EV_VALID   = 1'b1;
    EV_NOTE_ON = 1'b0;
    EV_NOTE    = mnote[0];
    chk("ev_ready_busy", EV_READY, 0);
    w = 0;
    while (EV_READY !== 1'b1 && w < 50) begin
      @(negedge CLK);
      w++;
    end
    chk("accept_cycle", cyc, k + 14);
    chk("sample_done_first", q.size(), 0);
    @(negedge CLK);
    EV_VALID = 1'b0;
    model_ev(0, mnote[0], d);
    chk("ev_drop_midsample", EV_DROP, d);
    push_sample(k + 16, NV, 1);
    @(negedge CLK);
    chk("count_after_off", ACTIVE_COUNT, mcount());
    @(negedge CLK);
    FIFO_FULL = 1'b1;
    drain();

    // Full FIFO in IDLE holds off sampling entirely
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("full_idle_quiet", {VOICE_STROBE, FIFO_WRITE}, 0);
    end

    // Reset during WAIT of slot 2 abandons the sample
    @(negedge CLK);
    k = cyc;
    push_sample(k, 3, 0);
    FIFO_FULL = 1'b0;
    @(negedge CLK);
    FIFO_FULL = 1'b1;
    repeat (7) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    model_reset();
    chk("midrst_fifo_write", FIFO_WRITE, 0);
    chk("midrst_count", ACTIVE_COUNT, 0);
    chk("midrst_ev_ready", EV_READY, 1);
    chk("midrst_strobe", VOICE_STROBE, 0);
    RESET = 1'b0;
    repeat (20) @(negedge CLK);
    chk("midrst_queue", q.size(), 0);
    run_samples(1, 0);
    send_ev(1, 7'd5);
    send_ev(1, 7'd127);
    run_samples(1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
